// File: rtl/pe_mac_sat.sv
// pe_mac_sat
//   Horizontal processing element for the output-stationary systolic array.
//   Signed fixed-point Q(DW-1-FRAC).FRAC multiply-accumulate with a two-stage
//   MAC pipeline (operand register, product register, accumulator). It
//   saturates both the product and the accumulator, and has a sticky
//   saturation flag.
//
//   Compile-time option: define PE_ROUND_NEAREST_EN to round the product half
//   up before slicing. When it is undefined, the product is truncated (floor).
//
//   Parameters
//     DW    data/accumulator width, 8..32
//     FRAC  fractional bits, 1..DW-2
//
//   Ports
//     clk, rst           clock (rising edge), synchronous active-low reset
//     en_in              MAC pipeline enable (stalls stages 0..2 when low)
//     valid_in           operand pair valid for accumulation
//     weight_in/ifmap_in signed operands
//     clear_psum         clear accumulator and sticky flag (ignores en_in)
//     en_out             output chain register enable
//     output_eject_ctrl  1: pass output_in along the chain, 0: load own psum
//     output_in          output chain input from the upstream PE
//     weight_out/ifmap_out/valid_out  registered operands to neighbours
//     output_out         output chain register
//     psum_out           accumulator value
//     sat_flag           sticky saturation flag
//
//   Handshake: valid only, no back-pressure. An operand pair is taken on
//   every clk edge with en_in=1. valid_in marks whether that pair
//   accumulates. Invalid pairs still move to the neighbours.
module pe_mac_sat #(
   parameter int DW   = 20,
   parameter int FRAC = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en_in,
   input  logic          valid_in,
   input  logic [DW-1:0] weight_in,
   input  logic [DW-1:0] ifmap_in,
   input  logic          clear_psum,
   input  logic          en_out,
   input  logic          output_eject_ctrl,
   input  logic [DW-1:0] output_in,
   output logic [DW-1:0] weight_out,
   output logic [DW-1:0] ifmap_out,
   output logic          valid_out,
   output logic [DW-1:0] output_out,
   output logic [DW-1:0] psum_out,
   output logic          sat_flag
);

   localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

   // Pipeline state
   logic [DW-1:0] weight_reg, ifmap_reg;
   logic          valid_reg;
   logic [DW-1:0] prod_reg;
   logic          prod_valid;
   logic          prod_sat;    // the product in prod_reg was saturated
   logic [DW-1:0] psum_reg;
   logic          sat_reg;
   logic [DW-1:0] output_reg;

   // Stage 1 combinational product
   logic [2*DW-1:0]  a_ext, b_ext, full, full_r;
   logic [DW-FRAC:0] upper;     // bits [2DW-1:FRAC+DW-1] must agree
   logic             p_ovf;
   logic [DW-1:0]    prod_next;
   logic             unused_lo;

`ifdef PE_ROUND_NEAREST_EN
   localparam logic [2*DW-1:0] RND = {{(2*DW-1){1'b0}}, 1'b1} << (FRAC-1);
`endif

   always_comb begin
      // Sign-extend first so that the 2*DW-bit product is exact.
      a_ext = {{DW{ifmap_reg[DW-1]}}, ifmap_reg};
      b_ext = {{DW{weight_reg[DW-1]}}, weight_reg};
      full  = a_ext * b_ext;
`ifdef PE_ROUND_NEAREST_EN
      full_r = full + RND;
`else
      full_r = full;
`endif
      upper     = full_r[2*DW-1:FRAC+DW-1];
      p_ovf     = !((&upper) || !(|upper));
      prod_next = full_r[FRAC+DW-1:FRAC];
      if (p_ovf) prod_next = full_r[2*DW-1] ? SAT_MIN : SAT_MAX;
   end

   assign unused_lo = ^full_r[FRAC-1:0];

   // Stage 2 combinational accumulate, one guard bit
   logic [DW:0]   sum;
   logic          acc_ovf;
   logic [DW-1:0] acc_next;
   logic          load;

   always_comb begin
      sum      = {psum_reg[DW-1], psum_reg} + {prod_reg[DW-1], prod_reg};
      acc_next = sum[DW-1:0];
      acc_ovf  = 1'b0;
      if (sum[DW:DW-1] == 2'b01) begin
         acc_next = SAT_MAX;
         acc_ovf  = 1'b1;
      end else if (sum[DW:DW-1] == 2'b10) begin
         acc_next = SAT_MIN;
         acc_ovf  = 1'b1;
      end
   end

   assign load = en_in && prod_valid;

   always_ff @(posedge clk) begin
      if (!rst) begin
         weight_reg <= '0;
         ifmap_reg  <= '0;
         valid_reg  <= 1'b0;
         prod_reg   <= '0;
         prod_valid <= 1'b0;
         prod_sat   <= 1'b0;
         psum_reg   <= '0;
         sat_reg    <= 1'b0;
         output_reg <= '0;
      end else begin
         if (en_in) begin
            weight_reg <= weight_in;
            ifmap_reg  <= ifmap_in;
            valid_reg  <= valid_in;
            prod_reg   <= prod_next;
            prod_valid <= valid_reg;
            prod_sat   <= valid_reg && p_ovf;
         end
         if (clear_psum) begin
            // On a clear-and-load edge the waiting product is kept, so that a
            // new stream can start without a bubble.
            psum_reg <= load ? prod_reg : '0;
            sat_reg  <= load && prod_sat;
         end else begin
            if (load) psum_reg <= acc_next;
            // A product that saturates flags here, and again when it is
            // consumed. The second set restores the flag if a clear
            // happened in between.
            sat_reg <= sat_reg || (en_in && valid_reg && p_ovf)
                               || (load && (prod_sat || acc_ovf));
         end
         // On a clear edge this takes the value of psum before the clear.
         if (en_out) output_reg <= output_eject_ctrl ? output_in : psum_reg;
      end
   end

   assign weight_out = weight_reg;
   assign ifmap_out  = ifmap_reg;
   assign valid_out  = valid_reg;
   assign output_out = output_reg;
   assign psum_out   = psum_reg;
   assign sat_flag   = sat_reg;

endmodule

// File: tb/tb_pe_mac_sat.sv
// Directed testbench for pe_mac_sat (DW=20, FRAC=10, Q9.10).
module tb_pe_mac_sat;

   localparam int DW   = 20;
   localparam int FRAC = 10;

`ifdef PE_ROUND_NEAREST_EN
   localparam int RND_POS = 1;   //  1x512 =  0.5 -> 1
   localparam int RND_NEG = 0;   // -1x512 = -0.5 -> 0
`else
   localparam int RND_POS = 0;
   localparam int RND_NEG = -1;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          en_in, valid_in, clear_psum, en_out, output_eject_ctrl;
   logic [DW-1:0] weight_in, ifmap_in, output_in;
   logic [DW-1:0] weight_out, ifmap_out, output_out, psum_out;
   logic          valid_out, sat_flag;

   int n_checks = 0;
   int n_errors = 0;
   logic [DW-1:0] exp_q[$];

   // ---------------- clock/reset ----------------
   always #5 clk = ~clk;

   pe_mac_sat #(.DW(DW), .FRAC(FRAC)) dut (
      .clk(clk), .rst(rst), .en_in(en_in), .valid_in(valid_in),
      .weight_in(weight_in), .ifmap_in(ifmap_in), .clear_psum(clear_psum),
      .en_out(en_out), .output_eject_ctrl(output_eject_ctrl),
      .output_in(output_in), .weight_out(weight_out), .ifmap_out(ifmap_out),
      .valid_out(valid_out), .output_out(output_out), .psum_out(psum_out),
      .sat_flag(sat_flag)
   );

   // ---------------- checking ----------------
   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int sx(input logic [DW-1:0] v);
      return int'($signed(v));
   endfunction

   // scoreboard: expected psum values, pushed before the stimulus
   task automatic sb_push(input int v);
      exp_q.push_back(DW'(v));
   endtask

   task automatic sb_check(input string tag);
      logic [DW-1:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 1, 0);
      end else begin
         e = exp_q.pop_front();
         check(tag, sx(psum_out), sx(e));
      end
   endtask

   // ---------------- driver ----------------
   // Apply the inputs, take one rising edge, then wait so that outputs are
   // sampled away from the edge.
   task automatic cyc(input logic en, input logic vld, input int w,
                      input int x, input logic clr);
      en_in      = en;
      valid_in   = vld;
      weight_in  = DW'(w);
      ifmap_in   = DW'(x);
      clear_psum = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_weight"}, sx(weight_out), 0);
      check({tag, "_ifmap"},  sx(ifmap_out), 0);
      check({tag, "_valid"},  int'(valid_out), 0);
      check({tag, "_output"}, sx(output_out), 0);
      check({tag, "_psum"},   sx(psum_out), 0);
      check({tag, "_sat"},    int'(sat_flag), 0);
   endtask

   initial begin
      // Assert reset while driving nonzero inputs: reset must win.
      rst = 1'b0; en_out = 1'b1; output_eject_ctrl = 1'b1;
      output_in = DW'(77);
      cyc(1, 1, 2048, 1536, 1);
      cyc(1, 1, 2048, 1536, 0);
      check_all_zero("reset");
      rst = 1'b1; en_out = 1'b0; output_eject_ctrl = 1'b0; output_in = '0;

      // Basic MAC: 1.5*2.0 then -1.5*2.0
      cyc(1, 1, 2048, 1536, 0);
      check("fwd_weight", sx(weight_out), 2048);
      check("fwd_ifmap",  sx(ifmap_out), 1536);
      check("fwd_valid",  int'(valid_out), 1);
      sb_push(0);    cyc(1, 1, 2048, -1536, 0); sb_check("mac_lat1");
      sb_push(3072); cyc(1, 0, 0, 0, 0);        sb_check("mac_first");
      sb_push(0);    cyc(1, 0, 0, 0, 0);        sb_check("mac_second");
      check("mac_sat", int'(sat_flag), 0);

      // Product saturation
      cyc(1, 1, 2048, 409600, 0);
      cyc(1, 0, 0, 0, 0);
      sb_push(524287); cyc(1, 0, 0, 0, 0); sb_check("psat_pos");
      check("psat_pos_flag", int'(sat_flag), 1);
      cyc(1, 1, 2048, -409600, 0);
      cyc(1, 0, 0, 0, 0);
      sb_push(-524288); cyc(1, 0, 0, 0, 1); sb_check("psat_neg_clrload");
      check("psat_neg_flag", int'(sat_flag), 1);
      sb_push(0); cyc(1, 0, 0, 0, 1); sb_check("psat_clear");
      check("psat_clear_flag", int'(sat_flag), 0);

      // Accumulator saturation
      cyc(1, 1, 1024, 524000, 0);
      cyc(1, 1, 1024, 1024, 0);
      sb_push(524000); cyc(1, 0, 0, 0, 0); sb_check("asat_pre");
      check("asat_pre_flag", int'(sat_flag), 0);
      sb_push(524287); cyc(1, 0, 0, 0, 0); sb_check("asat_clip");
      check("asat_flag", int'(sat_flag), 1);
      sb_push(0); cyc(1, 0, 0, 0, 1); sb_check("asat_clear");
      check("asat_clear_flag", int'(sat_flag), 0);

      // Stall for 3 cycles in the middle of a stream
      cyc(1, 1, 2048, 1536, 0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 999, 999, 0);
      sb_push(0); sb_check("stall_hold");
      check("stall_weight", sx(weight_out), 2048);
      sb_push(0);    cyc(1, 0, 0, 0, 0); sb_check("stall_lat1");
      sb_push(3072); cyc(1, 0, 0, 0, 0); sb_check("stall_result");

      // Clear-and-load: the product that arrives with the clear is kept
      cyc(1, 1, 2048, 1536, 0);
      cyc(1, 0, 0, 0, 0);
      sb_push(3072); cyc(1, 0, 0, 0, 1); sb_check("clear_load");
      check("clear_load_flag", int'(sat_flag), 0);

      // Output chain
      en_out = 1'b1; output_eject_ctrl = 1'b0;
      cyc(1, 0, 0, 0, 0);
      check("chain_load", sx(output_out), 3072);
      en_out = 1'b0; output_eject_ctrl = 1'b1; output_in = DW'(-5);
      cyc(1, 0, 0, 0, 0);
      check("chain_hold", sx(output_out), 3072);
      en_out = 1'b1;
      cyc(1, 0, 0, 0, 0);
      check("chain_pass", sx(output_out), -5);
      output_eject_ctrl = 1'b0;
      sb_push(0); cyc(1, 0, 0, 0, 1); sb_check("chain_clear_psum");
      check("chain_preclear", sx(output_out), 3072);
      en_out = 1'b0;

      // Rounding versus truncation
      cyc(1, 1, 512, 1, 0);
      cyc(1, 0, 0, 0, 0);
      sb_push(RND_POS); cyc(1, 0, 0, 0, 0); sb_check("round_pos");
      cyc(1, 1, 512, -1, 0);
      cyc(1, 0, 0, 0, 0);
      sb_push(RND_NEG); cyc(1, 0, 0, 0, 1); sb_check("round_neg");
      check("round_flag", int'(sat_flag), 0);

      // Reset in the middle of a stream
      en_out = 1'b1;
      cyc(1, 1, 2048, 1536, 0);
      cyc(1, 1, 2048, 1536, 0);
      cyc(1, 1, 2048, 1536, 0);
      rst = 1'b0;
      cyc(1, 1, 2048, 1536, 0);
      check_all_zero("rst_mid");
      rst = 1'b1; en_out = 1'b0;
      cyc(1, 1, 2048, 1536, 0);
      sb_push(0);    sb_check("post_rst_lat0");
      sb_push(0);    cyc(1, 0, 0, 0, 0); sb_check("post_rst_lat1");
      sb_push(3072); cyc(1, 0, 0, 0, 0); sb_check("post_rst_result");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
